// File: rtl/dropout_mask_restore.sv
// dropout_mask_restore
//
// Receive-side counterpart of the random dropout stage. A 16-bit Fibonacci
// LFSR, seeded identically to the transmitter, regenerates the keep/drop
// mask for each beat. Bits the transmitter dropped are rebuilt from the last
// restored beat, or forced to 0 in the default build. Dropped bits are
// counted with saturation.
//
// Optional feature macro: DROPOUT_RESTORE_HOLD_EN
//   defined     : hold registers present, dropped bits take the last restored value
//   not defined : no hold registers, dataout = datain & mask
//
// Parameters
//   WIDTH      beat width, 1..8
//   LFSR_SEED  LFSR value after reset, must match the dropout stage
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   enable      block enable; low freezes all state
//   seed_load   strobe that loads seed into the LFSR (0 maps to LFSR_SEED)
//   seed        new LFSR value
//   in_valid    datain carries a beat
//   datain      post-dropout beat
//   out_valid   one-cycle pulse, dataout/mask_out valid
//   dataout     restored beat
//   mask_out    mask applied to the beat, 1 = kept
//   drop_count  saturating count of dropped bits since reset

module dropout_mask_restore #(
   parameter int          WIDTH     = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [15:0]      seed,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] datain,
   output logic             out_valid,
   output logic [WIDTH-1:0] dataout,
   output logic [WIDTH-1:0] mask_out,
   output logic [15:0]      drop_count
);

   logic [15:0]      lfsr;
   logic [15:0]      lfsr_next;
   logic [15:0]      seed_eff;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] restored;
   logic [3:0]       drops;
   logic             accept;
   logic             load;

   function automatic logic [3:0] count_drops(input logic [WIDTH-1:0] m);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!m[i]) n = n + 4'd1;
      end
      return n;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Seed load has priority over a beat in the same cycle; the beat is dropped.
   assign load      = enable & seed_load;
   assign accept    = enable & in_valid & ~seed_load;
   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   // A zero seed would lock the LFSR, so it falls back to the default seed.
   assign seed_eff  = (seed == 16'd0) ? LFSR_SEED : seed;
   assign drops     = count_drops(mask);

   // Each mask bit ORs two LFSR bits, so a bit is kept with probability 3/4.
   always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask[i] = lfsr[2*i] | lfsr[2*i+1];
      end
   end

`ifdef DROPOUT_RESTORE_HOLD_EN
   logic [WIDTH-1:0] hold;

   assign restored = (datain & mask) | (hold & ~mask);

   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= '0;
      end else if (load) begin
         hold <= '0;
      end else if (accept) begin
         hold <= restored;
      end
   end
`else
   assign restored = datain & mask;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr       <= LFSR_SEED;
         out_valid  <= 1'b0;
         dataout    <= '0;
         mask_out   <= '0;
         drop_count <= 16'd0;
      end else if (load) begin
         lfsr      <= seed_eff;
         out_valid <= 1'b0;
      end else if (accept) begin
         lfsr       <= lfsr_next;
         out_valid  <= 1'b1;
         dataout    <= restored;
         mask_out   <= mask;
         drop_count <= sat_add(drop_count, drops);
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dropout_mask_restore.sv
// Testbench for dropout_mask_restore (WIDTH = 8, default seed).
// Stimulus pushes the expected output and its expected arrival cycle into a
// scoreboard queue; an independent monitor pops and compares on every
// out_valid pulse, so gaps, extra pulses and latency errors all show up.

module tb_dropout_mask_restore;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        seed_load;
   logic [15:0] seed;
   logic        in_valid;
   logic [7:0]  datain;
   logic        out_valid;
   logic [7:0]  dataout;
   logic [7:0]  mask_out;
   logic [15:0] drop_count;

   typedef struct {
      logic [7:0]  data;
      logic [7:0]  mask;
      logic [15:0] cnt;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;

   // Expected dataout for beat 8'h00 after 8'hFF, and for 8'hAA as third beat.
`ifdef DROPOUT_RESTORE_HOLD_EN
   localparam logic [7:0] EXP_B = 8'h04;
   localparam logic [7:0] EXP_C = 8'h8E;
`else
   localparam logic [7:0] EXP_B = 8'h00;
   localparam logic [7:0] EXP_C = 8'h8A;
`endif

   dropout_mask_restore #(.WIDTH(8), .LFSR_SEED(16'hACE1)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .seed_load  (seed_load),
      .seed       (seed),
      .in_valid   (in_valid),
      .datain     (datain),
      .out_valid  (out_valid),
      .dataout    (dataout),
      .mask_out   (mask_out),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d: got dataout=%h mask=%h cnt=%h, required no output",
                     cyc, dataout, mask_out, drop_count);
         end else begin
            mon_e = sb.pop_front();
            if (dataout !== mon_e.data || mask_out !== mon_e.mask ||
                drop_count !== mon_e.cnt || cyc != mon_e.cyc) begin
               errors++;
               $display("FAIL output_beat: got data=%h mask=%h cnt=%h cyc=%0d, required data=%h mask=%h cnt=%h cyc=%0d",
                        dataout, mask_out, drop_count, cyc,
                        mon_e.data, mon_e.mask, mon_e.cnt, mon_e.cyc);
            end
         end
      end
   end

   task automatic drive(input logic r, input logic en, input logic sl,
                        input logic [15:0] sd, input logic iv, input logic [7:0] d);
      @(posedge clk);
      #1;
      reset     = r;
      enable    = en;
      seed_load = sl;
      seed      = sd;
      in_valid  = iv;
      datain    = d;
   endtask

   task automatic beat(input logic [7:0] d, input logic [7:0] m,
                       input logic [7:0] q, input logic [15:0] c);
      exp_t e;
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, d);
      e.data = q;
      e.mask = m;
      e.cnt  = c;
      e.cyc  = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic check_reset_state(input string tag);
      vectors++;
      if (out_valid !== 1'b0 || dataout !== 8'h00 || mask_out !== 8'h00 || drop_count !== 16'h0000) begin
         errors++;
         $display("FAIL %s: got valid=%b data=%h mask=%h cnt=%h, required all zero",
                  tag, out_valid, dataout, mask_out, drop_count);
      end
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      seed_load = 1'b0;
      seed      = 16'h0000;
      in_valid  = 1'b0;
      datain    = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset_state");

      // Disabled: beats and seed loads are ignored.
      repeat (5) drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 8'hFF);

      // Back-to-back beats from the reset seed.
      beat(8'hFF, 8'hED, 8'hED, 16'd2);
      beat(8'h00, 8'hF9, EXP_B, 16'd4);
      beat(8'hAA, 8'hDB, EXP_C, 16'd6);

      // Seed load of 0 with a beat: beat not consumed, LFSR back to default.
      drive(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 8'h55);
      beat(8'hFF, 8'hED, 8'hED, 16'd8);

      // Reset together with a beat and a seed load: nothing consumed.
      drive(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 8'hFF);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
      check_reset_state("reset_midstream");
      beat(8'hFF, 8'hED, 8'hED, 16'd2);

      // Fresh reset, then seed 0x0001 before every beat: mask 0x01, 7 drops each.
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      for (int n = 1; n <= 9362; n++) begin
         drive(1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 8'h00);
         beat(8'hFF, 8'h01, 8'h01, 16'(7 * n));
      end

      // Count sits at 0xFFFE; two more drops clamp to 0xFFFF, which then holds.
      drive(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00);
      beat(8'hFF, 8'hED, 8'hED, 16'hFFFF);
      beat(8'h00, 8'hF9, EXP_B, 16'hFFFF);
      beat(8'hAA, 8'hDB, EXP_C, 16'hFFFF);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);

      for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outputs still pending, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
